apb_mst_bridge: RTL and testbench

Single-outstanding APB initiator that converts a valid/ready request interface into APB setup/access transfers and returns a one-cycle response pulse carrying read data. It sits between the system-side request source (AHB-to-APB bridge or test sequencer) and the APB peripheral register blocks such as the UART configuration slave at 0x4000_1000. It drives psel/penable/pwrite/paddr/pwdata and samples prdata. Wait-state and error handling are optional.

---
 rtl/apb_pkg.sv | 23 ++
 rtl/apb_mst_bridge.sv | 113 +++++++++++
 tb/tb_apb_mst_bridge.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: bridge FSM states, peripheral base addresses
// and UART register offsets.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    localparam logic [31:0] UART_BASE = 32'h4000_1000;
    localparam logic [31:0] GPIO_BASE = 32'h4000_2000;

    localparam logic [7:0] UART_CFG      = 8'h00;
    localparam logic [7:0] UART_TOP_CTRL = 8'h04;
    localparam logic [7:0] UART_PE_CTRL  = 8'h08;
    localparam logic [7:0] UART_BAUD     = 8'h0C;
    localparam logic [7:0] UART_STAT     = 8'h10;
    localparam logic [7:0] UART_TXD      = 8'h14;
    localparam logic [7:0] UART_RXD      = 8'h18;
    localparam logic [7:0] UART_IRQ      = 8'h1C;

endpackage

// File: rtl/apb_mst_bridge.sv
// Single-outstanding APB initiator: valid/ready request in, SETUP/ACCESS
// transfer out, one-cycle rsp_valid pulse back with read data.
// Ports: clk, rst_n; req_* request side; rsp_* response side;
// psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr APB side.
// Optional APB_MST_PREADY_EN: honour pready/pslverr with TIMEOUT guard.
module apb_mst_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    state_t state, state_nx;
    logic   done;
    logic   err;
    logic   accept;

`ifdef APB_MST_PREADY_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    logic [CW-1:0] wait_cnt;

    // Timeout completes on the TIMEOUT-th stalled ACCESS cycle.
    assign done = (state == ACCESS) &&
                  (pready || (wait_cnt == CW'(TIMEOUT - 1)));
    assign err  = !pready || pslverr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !pready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    logic unused_apb_in;
    assign unused_apb_in = ^{pready, pslverr};
    assign done = (state == ACCESS);
    assign err  = 1'b0;
`endif

    assign req_ready = (state == IDLE) || done;
    assign accept    = req_valid && req_ready;
    assign psel      = (state != IDLE);
    assign penable   = (state == ACCESS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = SETUP;
            SETUP:   state_nx = ACCESS;
            ACCESS:  if (done) state_nx = accept ? SETUP : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request fields held until the next accept, not cleared in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwrite <= 1'b0;
            paddr  <= '0;
            pwdata <= '0;
        end else if (accept) begin
            pwrite <= req_write;
            paddr  <= req_addr;
            pwdata <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= done;
            if (done) begin
                rsp_rdata <= (pwrite || err) ? '0 : prdata;
                rsp_err   <= err;
            end
        end
    end

endmodule

// File: tb/tb_apb_mst_bridge.sv
// Directed bench for apb_mst_bridge with an APB register-slave model
// and a response scoreboard.
module tb_apb_mst_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready = 1'b1;
    logic        pslverr = 1'b0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q[$];
    logic [31:0] sl_reg [8];
    logic [31:0] mdl_reg [8];
    logic        manual = 1'b0;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_val = '0;
    int          passes = 0;
    int          fails = 0;
    int          total = 0;
    int          rsp_cnt = 0;
    int          acc;

    always #5 clk = ~clk;

    apb_mst_bridge dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    assign prdata = ovr_en ? ovr_val :
                    (psel && !pwrite) ? sl_reg[paddr[4:2]] : 32'h0;

    always @(posedge clk)
        if (psel && penable && pwrite && pready)
            sl_reg[paddr[4:2]] <= pwdata;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare responses, then record newly accepted requests.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid) begin
            rsp_cnt++;
            if (q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                e = q.pop_front();
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
        if (rst_n && !manual && req_valid && req_ready) begin
            if (req_write) begin
                mdl_reg[req_addr[4:2]] = req_wdata;
                q.push_back('{32'h0, 1'b0});
            end else begin
                q.push_back('{mdl_reg[req_addr[4:2]], 1'b0});
            end
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            sl_reg[i]  = 32'h0;
            mdl_reg[i] = 32'h0;
        end
        sl_reg[1]  = 32'h0808_0000;
        mdl_reg[1] = 32'h0808_0000;

        // reset state
        repeat (3) step();
        chk("rst_psel", 64'(psel), 64'd0);
        chk("rst_penable", 64'(penable), 64'd0);
        chk("rst_pwrite", 64'(pwrite), 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        chk("rst_pwdata", 64'(pwdata), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        rst_n = 1'b1;
        step();

        // write PE_CTRL, phase-by-phase timing
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h4000_1008;
        req_wdata = 32'h0160_F001;
        step();
        req_valid = 1'b0;
        chk("wr_t1_psel", 64'(psel), 64'd1);
        chk("wr_t1_penable", 64'(penable), 64'd0);
        chk("wr_t1_ready", 64'(req_ready), 64'd0);
        chk("wr_paddr", 64'(paddr), 64'h4000_1008);
        chk("wr_pwdata", 64'(pwdata), 64'h0160_F001);
        chk("wr_pwrite", 64'(pwrite), 64'd1);
        step();
        chk("wr_t2_psel", 64'(psel), 64'd1);
        chk("wr_t2_penable", 64'(penable), 64'd1);
        chk("wr_t2_rspv", 64'(rsp_valid), 64'd0);
        step();
        chk("wr_t3_rspv", 64'(rsp_valid), 64'd1);
        chk("wr_t3_psel", 64'(psel), 64'd0);
        chk("wr_hold_paddr", 64'(paddr), 64'h4000_1008);
        step();
        chk("wr_t4_rspv", 64'(rsp_valid), 64'd0);

        // read back PE_CTRL, then TOP_CTRL reset value
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h4000_1008;
        step();
        req_valid = 1'b0;
        repeat (3) step();
        req_valid = 1'b1;
        req_addr  = 32'h4000_1004;
        step();
        req_valid = 1'b0;
        repeat (3) step();

        // back-to-back reads with req_valid held
        req_valid = 1'b1;
        req_addr  = 32'h4000_1008;
        step();
        chk("b2b_c1", 64'({psel, penable}), 64'b10);
        step();
        chk("b2b_c2", 64'({psel, penable}), 64'b11);
        chk("b2b_c2_ready", 64'(req_ready), 64'd1);
        req_addr = 32'h4000_1004;
        step();
        req_valid = 1'b0;
        chk("b2b_c3", 64'({psel, penable}), 64'b10);
        chk("b2b_c3_rspv", 64'(rsp_valid), 64'd1);
        step();
        chk("b2b_c4", 64'({psel, penable}), 64'b11);
        chk("b2b_c4_rspv", 64'(rsp_valid), 64'd0);
        step();
        chk("b2b_c5_psel", 64'(psel), 64'd0);
        chk("b2b_c5_rspv", 64'(rsp_valid), 64'd1);
        step();

        // reset asserted during ACCESS drops the transfer
        req_valid = 1'b1;
        req_addr  = 32'h4000_1004;
        step();
        req_valid = 1'b0;
        step();
        chk("mid_penable", 64'(penable), 64'd1);
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("mid_psel", 64'(psel), 64'd0);
        chk("mid_penable0", 64'(penable), 64'd0);
        chk("mid_rspv", 64'(rsp_valid), 64'd0);
        step();
        rst_n = 1'b1;
        chk("mid_ready", 64'(req_ready), 64'd1);
        repeat (3) step();

`ifdef APB_MST_PREADY_EN
        manual  = 1'b1;
        ovr_en  = 1'b1;
        ovr_val = 32'h1234;
        // three wait states
        pready = 1'b0;
        q.push_back('{32'h1234, 1'b0});
        req_valid = 1'b1;
        req_write = 1'b0;
        step();
        req_valid = 1'b0;
        acc = 0;
        for (int i = 0; i < 40 && psel; i++) begin
            if (penable) acc++;
            if (acc == 4) pready = 1'b1;
            step();
        end
        chk("ws_access_cycles", 64'(acc), 64'd4);
        step();

        // timeout
        pready = 1'b0;
        q.push_back('{32'h0, 1'b1});
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        acc = 0;
        for (int i = 0; i < 60 && psel; i++) begin
            if (penable) acc++;
            step();
        end
        chk("to_access_cycles", 64'(acc), 64'd16);
        step();

        // slave error
        pready  = 1'b1;
        pslverr = 1'b1;
        q.push_back('{32'h0, 1'b1});
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (3) step();
        pslverr = 1'b0;
        ovr_en  = 1'b0;
        manual  = 1'b0;
        chk("rsp_count", 64'(rsp_cnt), 64'd8);
`else
        chk("rsp_count", 64'(rsp_cnt), 64'd5);
`endif
        chk("sb_empty", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
